// File: rtl/add_mul_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : add_mul_result_collector
// Brief    : Frame statistics (sum/max/min/count) over the add/mul datapath
//            result stream, presented on a registered output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module add_mul_result_collector #(
    parameter int FRAME_LEN = 8,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_result,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_max,
    output logic [7:0]       out_min,
    output logic [7:0]       out_count,
    output logic             out_sat
);

    localparam logic [7:0]       c_frame_len = 8'(FRAME_LEN);
    localparam logic [ACC_W-1:0] c_sum_max   = {ACC_W{1'b1}};

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_sum;
    logic [7:0]       r_max;
    logic [7:0]       r_min;
    logic [7:0]       r_count;
    logic             r_sat;
    logic             r_first;
    logic [ACC_W-1:0] r_out_sum;
    logic [7:0]       r_out_max;
    logic [7:0]       r_out_min;
    logic [7:0]       r_out_count;
    logic             r_out_sat;

    logic             w_accept;
    logic [ACC_W:0]   w_sum_ext;
    logic [ACC_W-1:0] w_sum_post;
    logic [7:0]       w_max_post;
    logic [7:0]       w_min_post;
    logic [7:0]       w_cnt_post;
    logic             w_sat_post;
    logic             w_close;

    assign w_accept  = in_valid && r_in_ready;
    // One extra bit catches the carry-out that triggers saturation.
    assign w_sum_ext = {1'b0, r_sum} + {{(ACC_W + 1 - 8){1'b0}}, in_result};

    always_comb begin
        w_sum_post = r_sum;
        w_max_post = r_max;
        w_min_post = r_min;
        w_cnt_post = r_count;
        w_sat_post = r_sat;
        if (w_accept) begin
            w_cnt_post = r_count + 8'd1;
            if (w_sum_ext[ACC_W]) begin
                w_sum_post = c_sum_max;
                w_sat_post = 1'b1;
            end else begin
                w_sum_post = w_sum_ext[ACC_W-1:0];
            end
            if (r_first || (in_result > r_max)) w_max_post = in_result;
            if (r_first || (in_result < r_min)) w_min_post = in_result;
        end
    end

    assign w_close = (r_state == ST_ACCUM) &&
                     ((w_accept && (w_cnt_post == c_frame_len)) ||
                      (flush && (w_cnt_post != 8'd0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_max       <= '0;
            r_min       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_first     <= 1'b1;
            r_out_sum   <= '0;
            r_out_max   <= '0;
            r_out_min   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_close) begin
                        r_out_sum   <= w_sum_post;
                        r_out_max   <= w_max_post;
                        r_out_min   <= w_min_post;
                        r_out_count <= w_cnt_post;
                        r_out_sat   <= w_sat_post;
                        r_state     <= ST_HOLD;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_sum       <= '0;
                        r_max       <= '0;
                        r_min       <= '0;
                        r_count     <= '0;
                        r_sat       <= 1'b0;
                        r_first     <= 1'b1;
                    end else if (w_accept) begin
                        r_sum   <= w_sum_post;
                        r_max   <= w_max_post;
                        r_min   <= w_min_post;
                        r_count <= w_cnt_post;
                        r_sat   <= w_sat_post;
                        r_first <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // Returning to ACCUM costs one bubble before in_ready rises.
                    if (out_ready) begin
                        r_state     <= ST_ACCUM;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACCUM;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_max   = r_out_max;
    assign out_min   = r_out_min;
    assign out_count = r_out_count;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire
